// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MEM stage: byte-addressable data memory, branch resolve, MEM/WB register
module data_mem_stage #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int PC_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            branch_ne,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] write_data,
  input  logic            zero,
  input  logic [PC_W-1:0] pc_branch_in,
  output logic            pc_select,
  output logic [PC_W-1:0] pc_branch_out,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_mem_data,
  output logic            misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]   word_idx;
  logic            size_byte;
  logic            size_half;
  logic            access_misaligned;
  logic            do_store;
  logic [XLEN-1:0] rd_word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;

  assign pc_select     = branch & (zero ^ branch_ne);
  assign pc_branch_out = pc_branch_in;

  // Upper address bits are ignored so accesses wrap around the array.
  assign word_idx  = alu_result[AW+1:2];
  assign size_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
  assign size_half = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign access_misaligned = (mem_read | mem_write) &
                             ((size_half & alu_result[0]) |
                              (!size_byte & !size_half & (alu_result[1:0] != 2'b00)));

  assign do_store = mem_write & !stall & !flush & !access_misaligned & !rst;

  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[{alu_result[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{alu_result[1], 4'b0000} +: 16];

  // Reserved funct3 codes fall through to full-word behaviour.
  always_comb begin
    load_data = rd_word;
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Read-modify-write merge keeps the untouched byte lanes intact.
  always_comb begin
    store_word = rd_word;
    if (size_byte) begin
      store_word[{alu_result[1:0], 3'b000} +: 8] = write_data[7:0];
    end else if (size_half) begin
      store_word[{alu_result[1], 4'b0000} +: 16] = write_data[15:0];
    end else begin
      store_word = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[word_idx] <= store_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= 5'd0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      misaligned    <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= 1'b1;
      wb_reg_write  <= reg_write_in & !access_misaligned;
      wb_mem_to_reg <= mem_to_reg_in;
      wb_rd         <= rd_in;
      wb_alu_result <= alu_result;
      wb_mem_data   <= (mem_read & !mem_write & !access_misaligned) ? load_data : '0;
      misaligned    <= access_misaligned;
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - randomized bench with byte-level memory model for data_mem_stage
module tb_data_mem_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 256;
  localparam int PC_W  = 8;
  localparam int NBYTE = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, mem_read, mem_write, branch, branch_ne;
  logic reg_write_in, mem_to_reg_in, zero;
  logic [2:0] funct3;
  logic [4:0] rd_in;
  logic [XLEN-1:0] alu_result, write_data;
  logic [PC_W-1:0] pc_branch_in;
  logic pc_select, wb_valid, wb_reg_write, wb_mem_to_reg, misaligned;
  logic [PC_W-1:0] pc_branch_out;
  logic [4:0] wb_rd;
  logic [XLEN-1:0] wb_alu_result, wb_mem_data;

  data_mem_stage #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .branch_ne(branch_ne),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .funct3(funct3),
    .rd_in(rd_in), .alu_result(alu_result), .write_data(write_data), .zero(zero),
    .pc_branch_in(pc_branch_in), .pc_select(pc_select), .pc_branch_out(pc_branch_out),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .misaligned(misaligned)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  byte unsigned mb [NBYTE];
  logic e_valid = 1'b0, e_rw = 1'b0, e_m2r = 1'b0, e_mis = 1'b0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_alu = 32'd0, e_md = 32'd0;

  function automatic int acc_size(logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_mis(bit r, bit w, logic [2:0] f, logic [31:0] a);
    return (r || w) && ((a % acc_size(f)) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f, logic [31:0] a);
    int base = int'(a % NBYTE);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < acc_size(f); k++) v = v | (32'(mb[base + k]) << (8 * k));
    if (f == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      e_valid <= 1'b0; e_rw <= 1'b0; e_m2r <= 1'b0; e_mis <= 1'b0;
      e_rd <= 5'd0; e_alu <= 32'd0; e_md <= 32'd0;
    end else if (!stall) begin
      e_valid <= 1'b1;
      e_mis   <= is_mis(mem_read, mem_write, funct3, alu_result);
      e_rw    <= reg_write_in && !is_mis(mem_read, mem_write, funct3, alu_result);
      e_m2r   <= mem_to_reg_in;
      e_rd    <= rd_in;
      e_alu   <= alu_result;
      e_md    <= (mem_read && !mem_write && !is_mis(mem_read, mem_write, funct3, alu_result))
                 ? model_load(funct3, alu_result) : 32'd0;
      if (mem_write && !is_mis(mem_read, mem_write, funct3, alu_result))
        for (int k = 0; k < acc_size(funct3); k++)
          mb[int'(alu_result % NBYTE) + k] <= write_data[8*k +: 8];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_valid", 32'(wb_valid), 32'(e_valid));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(e_rw));
      chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e_m2r));
      chk("wb_rd", 32'(wb_rd), 32'(e_rd));
      chk("wb_alu_result", wb_alu_result, e_alu);
      chk("wb_mem_data", wb_mem_data, e_md);
      chk("misaligned", 32'(misaligned), 32'(e_mis));
      chk("pc_select", 32'(pc_select), 32'(branch && (branch_ne ? !zero : zero)));
      chk("pc_branch_out", 32'(pc_branch_out), 32'(pc_branch_in));
    end
  end

  task automatic op(bit r, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                    bit s = 1'b0, bit fl = 1'b0, bit rs = 1'b0);
    mem_read = r; mem_write = w; funct3 = f; alu_result = a; write_data = d;
    reg_write_in = 1'b1; mem_to_reg_in = r; rd_in = 5'(a[6:2] ^ 5'd7);
    stall = s; flush = fl; rst = rs;
    @(posedge clk); #2;
  endtask

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  initial begin
    logic [31:0] a;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    branch = 1'b0; branch_ne = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    zero = 1'b0; funct3 = 3'b0; rd_in = 5'd0; alu_result = '0; write_data = '0;
    pc_branch_in = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    chk("reset_valid", 32'(wb_valid), 32'd0);
    chk("reset_alu", wb_alu_result, 32'd0);
    chk("reset_mdata", wb_mem_data, 32'd0);
    chk("reset_rd", 32'(wb_rd), 32'd0);

    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, LW, 32'(i * 4), $urandom());

    op(0, 1, LW, 32'h4, 32'h1100_1100);
    op(0, 1, LW, 32'h8, 32'h0011_0011);
    op(1, 0, LW, 32'h8, 32'h0);
    chk("sw_then_lw", wb_mem_data, 32'h0011_0011);
    op(1, 0, LW, 32'h4, 32'h0);
    chk("lw_word1", wb_mem_data, 32'h1100_1100);

    op(0, 1, LW, 32'h0, 32'h8000_F0FF);
    op(1, 0, LB, 32'h0, 32'h0);  chk("lb_0", wb_mem_data, 32'hFFFF_FFFF);
    op(1, 0, LBU, 32'h1, 32'h0); chk("lbu_1", wb_mem_data, 32'h0000_00F0);
    op(1, 0, LH, 32'h2, 32'h0);  chk("lh_2", wb_mem_data, 32'hFFFF_8000);
    op(1, 0, LHU, 32'h2, 32'h0); chk("lhu_2", wb_mem_data, 32'h0000_8000);

    op(0, 1, LW, 32'h0, 32'h1234_5678);
    op(0, 1, LB, 32'h3, 32'h0000_00AB);
    op(1, 0, LW, 32'h0, 32'h0);  chk("sb_lane3", wb_mem_data, 32'hAB34_5678);
    op(0, 1, LH, 32'h1, 32'h0000_BEEF);
    chk("sh_misaligned", 32'(misaligned), 32'd1);
    chk("sh_mis_regwrite", 32'(wb_reg_write), 32'd0);
    op(1, 0, LW, 32'h0, 32'h0);  chk("sh_mis_nowrite", wb_mem_data, 32'hAB34_5678);

    branch = 1'b1; zero = 1'b1; branch_ne = 1'b0; pc_branch_in = 8'h33; #1;
    chk("beq_taken", 32'(pc_select), 32'd1);
    chk("branch_target", 32'(pc_branch_out), 32'h33);
    branch_ne = 1'b1; #1;
    chk("bne_not_taken", 32'(pc_select), 32'd0);
    branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;

    op(1, 0, LW, 32'h4, 32'h0);
    op(0, 1, LW, 32'h0, 32'hDEAD_BEEF, 1'b1);
    chk("stall_hold_alu", wb_alu_result, 32'h4);
    chk("stall_hold_mdata", wb_mem_data, 32'h1100_1100);
    op(1, 0, LW, 32'h0, 32'h0);  chk("stall_no_write", wb_mem_data, 32'hAB34_5678);
    op(1, 0, LW, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("flush_over_stall", 32'(wb_valid), 32'd0);
    op(1, 0, LW, 32'h4, 32'h0);
    op(1, 0, LW, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_stall_valid", 32'(wb_valid), 32'd0);
    chk("rst_mid_stall_alu", wb_alu_result, 32'd0);
    op(1, 0, LW, 32'(DEPTH * 4 + 4), 32'h0);
    chk("post_rst_valid", 32'(wb_valid), 32'd1);
    chk("wrap_lw", wb_mem_data, 32'h1100_1100);

    for (int n = 0; n < 2000; n++) begin
      a = $urandom();
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      else if ($urandom_range(1) != 0) a[0] = 1'b0;
      mem_read = 1'($urandom_range(1)); mem_write = ($urandom_range(99) < 35);
      funct3 = 3'($urandom_range(7)); alu_result = a; write_data = $urandom();
      reg_write_in = 1'($urandom_range(1)); mem_to_reg_in = 1'($urandom_range(1));
      rd_in = 5'($urandom_range(31));
      rst = ($urandom_range(99) < 2); stall = ($urandom_range(99) < 12);
      flush = ($urandom_range(99) < 8);
      branch = 1'($urandom_range(1)); branch_ne = 1'($urandom_range(1));
      zero = 1'($urandom_range(1)); pc_branch_in = 8'($urandom_range(255));
      @(posedge clk); #2;
    end

    op(0, 0, LW, 32'h0, 32'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter XLEN, default 32: data/address width in bits.
REQ-002 Parameter DEPTH_WORDS, default 256: data memory depth in XLEN-bit words; power of two.
REQ-003 Parameter PC_W, default 8: branch target width.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hold MEM/WB register, suppress memory write.
REQ-007 flush  in  1  replace current MEM instruction with bubble.
REQ-008 mem_read, mem_write, branch, branch_ne, reg_write_in, mem_to_reg_in  in  1 each  EX/MEM control bits.
REQ-009 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 rd_in  in  5  destination register.
REQ-011 alu_result  in  XLEN  byte address / pass-through value.
REQ-012 write_data  in  XLEN  store data, right-aligned.
REQ-013 zero  in  1  ALU zero flag.
REQ-014 pc_branch_in  in  PC_W  branch target.
REQ-015 pc_select  out  1  take branch; pc_branch_out  out  PC_W  target.
REQ-016 wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  registered MEM/WB controls.
REQ-017 wb_rd  out  5; wb_alu_result  out  XLEN; wb_mem_data  out  XLEN  registered MEM/WB data.
REQ-018 misaligned  out  1  registered: access in MEM/WB faulted.

Function
REQ-019 Word index SHALL be alu_result[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap).
REQ-020 pc_select SHALL be combinational: branch & (zero XOR branch_ne); pc_branch_out = pc_branch_in, same cycle, regardless of stall/flush.
REQ-021 Misaligned SHALL mean (mem_read|mem_write) with: H/HU and addr[0]=1; W and addr[1:0]!=0.
REQ-022 Store, on clk edge when mem_write & !stall & !flush & !misaligned & !rst: SB writes byte lane addr[1:0]; SH writes half lane addr[1]; SW writes full word; other lanes unchanged.
REQ-023 Load data SHALL come from pre-edge memory contents; lane selected by addr; B/H sign-extended, BU/HU zero-extended, W unmodified; reserved funct3 treated as W for loads and stores.
REQ-024 MEM/WB register SHALL update every edge unless stall; latency one cycle from EX/MEM inputs to wb_* outputs.
REQ-025 Normal update: wb_valid=1, wb_reg_write=reg_write_in & !misaligned, wb_mem_to_reg=mem_to_reg_in, wb_rd=rd_in, wb_alu_result=alu_result, wb_mem_data=load data if mem_read & !mem_write & !misaligned else 0, misaligned per REQ-021.
REQ-026 Flush SHALL load bubble: all wb_* and misaligned = 0; flush has priority over stall.
REQ-027 Stall (no flush): all wb_* and misaligned hold; no memory write.
REQ-028 mem_read and mem_write both high: store performed, wb_mem_data=0.
REQ-029 Store at edge N followed by load of same word at edge N+1 SHALL return stored data.

Reset
REQ-030 rst at an edge SHALL clear wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, misaligned to 0; rst has priority over stall/flush.
REQ-031 rst SHALL suppress memory writes in that cycle; memory contents are not cleared.
REQ-032 Reset asserted mid-stall SHALL still clear the register; first post-reset instruction completes normally.

Verification
REQ-033 mem[1]=0x11001100; SW addr 0x8 data 0x00110011, next cycle LW addr 0x8 -> wb_mem_data=0x00110011; LW addr 0x4 -> 0x11001100.
REQ-034 mem[0]=0x8000F0FF; LB 0x0 -> 0xFFFFFFFF; LBU 0x1 -> 0x000000F0; LH 0x2 -> 0xFFFF8000; LHU 0x2 -> 0x00008000.
REQ-035 SB addr 0x3 data 0x000000AB onto 0x12345678 -> word 0xAB345678; SH addr 0x1 -> misaligned=1, wb_reg_write=0, memory unchanged.
REQ-036 branch=1, zero=1, branch_ne=0, pc_branch_in=0x33 -> pc_select=1, pc_branch_out=0x33 same cycle; branch_ne=1 -> pc_select=0.
REQ-037 stall=1 with SW pending -> memory unchanged, wb_* held; stall=1 and flush=1 -> wb_valid=0; rst=1 -> all wb_* 0.
REQ-038 LW addr DEPTH_WORDS*4+0x4 -> same data as addr 0x4 (wrap).
